// File: rtl/dec_inst_queue.sv
// Decoded-instruction FIFO between the decoder and microcode stages.
// Optional zero-latency empty path enabled by defining DEC_QUEUE_BYPASS_EN.
module dec_inst_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PAYLOAD_W = 157
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [PAYLOAD_W-1:0]       in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [PAYLOAD_W-1:0]       out_data,
    input  logic                       micro_busy,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [PAYLOAD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_wr_en;
    logic                 w_rd_adv;
    logic [PAYLOAD_W-1:0] w_head;

    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == FULL_LVL);
    assign w_head   = r_mem[r_rd_ptr];

    // Ready depends only on registered occupancy, never on micro_busy.
    assign in_ready = ~w_full;
    assign level    = r_level;

`ifdef DEC_QUEUE_BYPASS_EN
    logic w_bypass;

    assign w_bypass = w_empty & in_valid;

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        if (!w_empty) begin
            out_valid = 1'b1;
            out_data  = w_head;
        end else if (in_valid) begin
            out_valid = 1'b1;
            out_data  = in_data;
        end
    end

    assign w_push   = in_valid & in_ready;
    assign w_pop    = out_valid & ~micro_busy;
    // A bypassed word consumed in the same cycle never touches storage.
    assign w_wr_en  = w_push & ~(w_bypass & w_pop);
    assign w_rd_adv = w_pop & ~w_bypass;
`else
    always_comb begin
        out_valid = ~w_empty;
        out_data  = '0;
        if (!w_empty) begin
            out_data = w_head;
        end
    end

    assign w_push   = in_valid & in_ready;
    assign w_pop    = out_valid & ~micro_busy;
    assign w_wr_en  = w_push;
    assign w_rd_adv = w_pop;
`endif

    always_ff @(posedge clk) begin
        if (w_wr_en && !flush) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_wr_en && !w_rd_adv) begin
                r_level <= r_level + LW'(1);
            end else if (!w_wr_en && w_rd_adv) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dec_inst_queue.sv
// Directed self-checking bench for dec_inst_queue (DEPTH=4, PAYLOAD_W=157).
// Builds with or without DEC_QUEUE_BYPASS_EN; only the empty-path scenario differs.
module tb_dec_inst_queue;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned PAYLOAD_W = 157;

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic                 in_valid;
    logic [PAYLOAD_W-1:0] in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic [PAYLOAD_W-1:0] out_data;
    logic                 micro_busy;
    logic [2:0]           level;

    int unsigned n_checks;
    int unsigned n_errors;

    dec_inst_queue #(
        .DEPTH     (DEPTH),
        .PAYLOAD_W (PAYLOAD_W)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .micro_busy (micro_busy),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Distinct non-zero payload per index.
    function automatic logic [PAYLOAD_W-1:0] pay(input int unsigned k);
        logic [159:0] t;
        t = {5{32'h9E37_0000 + k}};
        return t[PAYLOAD_W-1:0];
    endfunction

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PAYLOAD_W-1:0] cmdword;
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        micro_busy = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_level", 160'(level), 160'(0));
        check("rst_out_valid", 160'(out_valid), 160'(0));
        check("rst_out_data", 160'(out_data), 160'(0));
        check("rst_in_ready", 160'(in_ready), 160'(1));

        // Fill to full with microcode busy; head stays at the first entry.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = pay(i);
            #1;
            check("fill_ready", 160'(in_ready), 160'(1));
            tick();
            check("fill_level", 160'(level), 160'(i + 1));
            check("fill_head", 160'(out_data), 160'(pay(0)));
        end
        check("full_in_ready", 160'(in_ready), 160'(0));

        // Fifth push refused while full and busy.
        in_data = pay(4);
        tick();
        check("full_refuse_level", 160'(level), 160'(4));
        check("full_hold_head", 160'(out_data), 160'(pay(0)));

        // Full + pop with in_valid still high: push refused, level drops.
        micro_busy = 1'b0;
        #1;
        check("pop0_data", 160'(out_data), 160'(pay(0)));
        tick();
        check("full_pop_level", 160'(level), 160'(3));
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check("drain_data", 160'(out_data), 160'(pay(i)));
            tick();
            check("drain_level", 160'(level), 160'(3 - i));
        end
        check("drain_out_valid", 160'(out_valid), 160'(0));
        check("drain_out_data", 160'(out_data), 160'(0));

        // Steady stream at level 2 across pointer wrap.
        micro_busy = 1'b1;
        in_valid   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = pay(100 + i);
            tick();
        end
        check("stream_start_level", 160'(level), 160'(2));
        micro_busy = 1'b0;
        for (int i = 2; i < 12; i++) begin
            in_data = pay(100 + i);
            #1;
            check("stream_head", 160'(out_data), 160'(pay(100 + i - 2)));
            tick();
            check("stream_level", 160'(level), 160'(2));
        end
        in_valid = 1'b0;
        check("stream_tail0", 160'(out_data), 160'(pay(110)));
        tick();
        check("stream_tail1", 160'(out_data), 160'(pay(111)));
        tick();
        check("stream_empty", 160'(level), 160'(0));

        // Flush at level 3 with simultaneous push and pop.
        micro_busy = 1'b1;
        in_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = pay(200 + i);
            tick();
        end
        check("preflush_level", 160'(level), 160'(3));
        flush      = 1'b1;
        micro_busy = 1'b0;
        in_data    = pay(203);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_level", 160'(level), 160'(0));
        check("flush_out_valid", 160'(out_valid), 160'(0));
        micro_busy = 1'b1;
        in_valid   = 1'b1;
        in_data    = pay(300);
        tick();
        in_valid = 1'b0;
        check("postflush_head", 160'(out_data), 160'(pay(300)));
        check("postflush_level", 160'(level), 160'(1));
        micro_busy = 1'b0;
        tick();
        check("postflush_empty", 160'(out_valid), 160'(0));

        // Empty-path latency with cmd=7'h12.
        cmdword        = '0;
        cmdword[11:5]  = 7'h12;
        micro_busy     = 1'b0;
        in_valid       = 1'b1;
        in_data        = cmdword;
        #1;
`ifdef DEC_QUEUE_BYPASS_EN
        check("byp_out_valid", 160'(out_valid), 160'(1));
        check("byp_cmd", 160'(out_data[11:5]), 160'(7'h12));
        tick();
        in_valid = 1'b0;
        check("byp_level", 160'(level), 160'(0));
        #1;
        check("byp_after_valid", 160'(out_valid), 160'(0));
`else
        check("nobyp_out_valid0", 160'(out_valid), 160'(0));
        tick();
        in_valid = 1'b0;
        check("nobyp_out_valid1", 160'(out_valid), 160'(1));
        check("nobyp_cmd", 160'(out_data[11:5]), 160'(7'h12));
        check("nobyp_level", 160'(level), 160'(1));
        tick();
        check("nobyp_drained", 160'(level), 160'(0));
`endif

        // Reset mid-stream at level 2.
        micro_busy = 1'b1;
        in_valid   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = pay(400 + i);
            tick();
        end
        check("prerst_level", 160'(level), 160'(2));
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_level", 160'(level), 160'(0));
        check("midrst_out_valid", 160'(out_valid), 160'(0));
        check("midrst_in_ready", 160'(in_ready), 160'(1));
        check("midrst_out_data", 160'(out_data), 160'(0));
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = pay(500 + i);
            tick();
        end
        in_valid   = 1'b0;
        micro_busy = 1'b0;
        #1;
        check("postrst_first", 160'(out_data), 160'(pay(500)));
        tick();
        check("postrst_second", 160'(out_data), 160'(pay(501)));
        tick();
        check("postrst_empty", 160'(level), 160'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
